// File: rtl/ysyx_040750_hazard_unit.sv
// Load-use and forwarding-match tracker for the 5-stage pipeline (ID_EX, EX_MEM, MEM_WB, WB slots).
// Optional event counters are enabled with `define YSYX_040750_HAZARD_STAT_EN.
module ysyx_040750_hazard_unit #(
    parameter int REG_AW    = 5,
    parameter int NREG_ZERO = 0
) (
    input  logic              I_sys_clk,
    input  logic              I_rst,
    input  logic              I_ID_valid,
    input  logic [REG_AW-1:0] I_ID_rs1,
    input  logic [REG_AW-1:0] I_ID_rs2,
    input  logic              I_ID_rs1_use,
    input  logic              I_ID_rs2_use,
    input  logic [REG_AW-1:0] I_ID_rd,
    input  logic              I_ID_reg_wen,
    input  logic              I_ID_is_load,
    input  logic              I_pipe_hold,
    input  logic              I_flush,
    output logic [1:0]        O_EX_stall,
    output logic [1:0]        O_MEM_stall,
    output logic [1:0]        O_WB_stall,
    output logic              O_EX_reg_wen,
    output logic              O_MEM_reg_wen,
    output logic              O_WB_reg_wen,
    output logic              O_IF_ID_hold,
    output logic              O_ID_EX_bubble
`ifdef YSYX_040750_HAZARD_STAT_EN
    ,
    output logic [31:0]       O_lu_stall_cnt,
    output logic [31:0]       O_fwd_cnt
`endif
);

    localparam logic [REG_AW-1:0] ZERO = REG_AW'(NREG_ZERO);

    // Slot k: 0 = ID_EX, 1 = EX_MEM, 2 = MEM_WB, 3 = WB
    logic [3:0]        vld_q;
    logic [3:0]        wen_q;
    logic [3:0]        ld_q;
    logic [REG_AW-1:0] rd_q [4];

    logic [1:0] ex_stall_q, mem_stall_q, wb_stall_q;
    logic [1:0] ex_stall_d, mem_stall_d, wb_stall_d;
    logic       flush_pend_q;

    logic [2:0] hit1, hit2;
    logic       advance, flush_eff, load_use, bubble, kill;

    function automatic logic hit(input logic use_i, input logic [REG_AW-1:0] rs,
                                 input logic [REG_AW-1:0] rd, input logic wen,
                                 input logic vld);
        return use_i & (rs != ZERO) & (rs == rd) & wen & vld;
    endfunction

    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int k = 0; k < 3; k++) begin
            hit1[k] = hit(I_ID_rs1_use, I_ID_rs1, rd_q[k], wen_q[k], vld_q[k]);
            hit2[k] = hit(I_ID_rs2_use, I_ID_rs2, rd_q[k], wen_q[k], vld_q[k]);
        end
    end

    // A flush seen while frozen is remembered so it lands on the first advancing edge.
    assign advance   = ~I_pipe_hold;
    assign flush_eff = I_flush | flush_pend_q;
    assign load_use  = vld_q[0] & ld_q[0] & wen_q[0] & (hit1[0] | hit2[0]);
    assign bubble    = load_use & ~flush_eff;
    assign kill      = bubble | flush_eff;

    assign O_IF_ID_hold   = bubble;
    assign O_ID_EX_bubble = bubble;

    // A load in ID_EX can never forward from EX_MEM; the bubble re-aligns it to MEM.
    always_comb begin
        ex_stall_d  = '0;
        mem_stall_d = '0;
        wb_stall_d  = '0;
        if (!kill) begin
            ex_stall_d  = {hit1[0] & ~ld_q[0], hit2[0] & ~ld_q[0]};
            mem_stall_d = {hit1[1], hit2[1]};
            wb_stall_d  = {hit1[2], hit2[2]};
        end
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            vld_q        <= '0;
            ex_stall_q   <= '0;
            mem_stall_q  <= '0;
            wb_stall_q   <= '0;
            flush_pend_q <= 1'b0;
        end else if (advance) begin
            vld_q        <= {vld_q[2], vld_q[1], vld_q[0] & ~flush_eff, I_ID_valid & ~kill};
            ex_stall_q   <= ex_stall_d;
            mem_stall_q  <= mem_stall_d;
            wb_stall_q   <= wb_stall_d;
            flush_pend_q <= 1'b0;
        end else if (I_flush) begin
            flush_pend_q <= 1'b1;
        end
    end

    // Slot payload is qualified by vld_q, so it needs no reset.
    always_ff @(posedge I_sys_clk) begin
        if (advance) begin
            rd_q[0] <= I_ID_rd;
            rd_q[1] <= rd_q[0];
            rd_q[2] <= rd_q[1];
            rd_q[3] <= rd_q[2];
            wen_q   <= {wen_q[2:0], I_ID_reg_wen};
            ld_q    <= {ld_q[2:0], I_ID_is_load};
        end
    end

    assign O_EX_stall    = ex_stall_q;
    assign O_MEM_stall   = mem_stall_q;
    assign O_WB_stall    = wb_stall_q;
    assign O_EX_reg_wen  = vld_q[1] & wen_q[1] & (rd_q[1] != ZERO);
    assign O_MEM_reg_wen = vld_q[2] & wen_q[2] & (rd_q[2] != ZERO);
    assign O_WB_reg_wen  = vld_q[3] & wen_q[3] & (rd_q[3] != ZERO);

`ifdef YSYX_040750_HAZARD_STAT_EN
    logic [31:0] lu_cnt_q, fwd_cnt_q;
    logic        fwd_any;

    assign fwd_any = |{ex_stall_q, mem_stall_q, wb_stall_q};

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            lu_cnt_q  <= '0;
            fwd_cnt_q <= '0;
        end else if (advance) begin
            if (bubble && (lu_cnt_q != '1))
                lu_cnt_q <= lu_cnt_q + 32'd1;
            if (fwd_any && (fwd_cnt_q != '1))
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
        end
    end

    assign O_lu_stall_cnt = lu_cnt_q;
    assign O_fwd_cnt      = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_040750_hazard_unit.sv
// Directed bench for ysyx_040750_hazard_unit: per-cycle reference model plus literal spot checks.
module tb_ysyx_040750_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 0, rs1_use = 0, rs2_use = 0, reg_wen = 0, is_load = 0;
    logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
    logic       pipe_hold = 0, flush = 0;
    logic [1:0] ex_stall, mem_stall, wb_stall;
    logic       ex_wen, mem_wen, wb_wen, if_hold, bubble;
`ifdef YSYX_040750_HAZARD_STAT_EN
    logic [31:0] lu_cnt, fwd_cnt;
`endif

    int checks = 0;
    int failures = 0;

    ysyx_040750_hazard_unit #(.REG_AW(5), .NREG_ZERO(0)) dut (
        .I_sys_clk     (clk),
        .I_rst         (rst),
        .I_ID_valid    (id_valid),
        .I_ID_rs1      (rs1),
        .I_ID_rs2      (rs2),
        .I_ID_rs1_use  (rs1_use),
        .I_ID_rs2_use  (rs2_use),
        .I_ID_rd       (rd),
        .I_ID_reg_wen  (reg_wen),
        .I_ID_is_load  (is_load),
        .I_pipe_hold   (pipe_hold),
        .I_flush       (flush),
        .O_EX_stall    (ex_stall),
        .O_MEM_stall   (mem_stall),
        .O_WB_stall    (wb_stall),
        .O_EX_reg_wen  (ex_wen),
        .O_MEM_reg_wen (mem_wen),
        .O_WB_reg_wen  (wb_wen),
        .O_IF_ID_hold  (if_hold),
        .O_ID_EX_bubble(bubble)
`ifdef YSYX_040750_HAZARD_STAT_EN
        ,
        .O_lu_stall_cnt(lu_cnt),
        .O_fwd_cnt     (fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the pipeline as a list of in-flight instructions, position = stage.
    typedef struct packed {
        bit       v;
        bit [4:0] rd;
        bit       wen;
        bit       ld;
    } instr_t;

    instr_t   pipe [4];
    bit [1:0] m_ex, m_mem, m_wb;
    bit       m_flush_pending;
    bit       m_fl, m_lu;
    instr_t   m_new;

    function automatic bit reads(instr_t p, bit [4:0] rs, bit use_);
        return use_ && rs != 0 && p.v && p.wen && p.rd == rs;
    endfunction

    function automatic bit load_use_now();
        return pipe[0].ld && (reads(pipe[0], rs1, rs1_use) || reads(pipe[0], rs2, rs2_use))
               && !(flush || m_flush_pending);
    endfunction

    function automatic bit writes(instr_t p);
        return p.v && p.wen && p.rd != 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) pipe[i] = '0;
            m_ex = 0; m_mem = 0; m_wb = 0; m_flush_pending = 0;
        end else if (pipe_hold) begin
            if (flush) m_flush_pending = 1;
        end else begin
            m_fl = flush || m_flush_pending;
            m_lu = load_use_now();
            if (m_fl || m_lu) begin
                m_ex = 0; m_mem = 0; m_wb = 0;
            end else begin
                // producer at distance 1 (ID_EX) cannot forward if it is a load
                m_ex  = pipe[0].ld ? 2'b00 : {reads(pipe[0], rs1, rs1_use), reads(pipe[0], rs2, rs2_use)};
                m_mem = {reads(pipe[1], rs1, rs1_use), reads(pipe[1], rs2, rs2_use)};
                m_wb  = {reads(pipe[2], rs1, rs1_use), reads(pipe[2], rs2, rs2_use)};
            end
            m_new.v   = id_valid && !m_fl && !m_lu;
            m_new.rd  = rd;
            m_new.wen = reg_wen;
            m_new.ld  = is_load;
            for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
            if (m_fl) pipe[1].v = 0;
            pipe[0] = m_new;
            m_flush_pending = 0;
        end
    end

    always @(negedge clk) begin
        chk("if_id_hold", {31'd0, if_hold}, {31'd0, load_use_now()});
        chk("id_ex_bubble", {31'd0, bubble}, {31'd0, load_use_now()});
        chk("ex_stall", {30'd0, ex_stall}, {30'd0, m_ex});
        chk("mem_stall", {30'd0, mem_stall}, {30'd0, m_mem});
        chk("wb_stall", {30'd0, wb_stall}, {30'd0, m_wb});
        chk("ex_reg_wen", {31'd0, ex_wen}, {31'd0, writes(pipe[1])});
        chk("mem_reg_wen", {31'd0, mem_wen}, {31'd0, writes(pipe[2])});
        chk("wb_reg_wen", {31'd0, wb_wen}, {31'd0, writes(pipe[3])});
    end

    task automatic id(input bit v, input int d, input bit w, input bit l,
                      input int s1, input bit u1, input int s2, input bit u2);
        id_valid = v; rd = 5'(d); reg_wen = w; is_load = l;
        rs1 = 5'(s1); rs1_use = u1; rs2 = 5'(s2); rs2_use = u2;
    endtask

    task automatic nop();
        id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (4) tick();
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_vec"}, {26'd0, ex_stall, mem_stall, wb_stall}, 32'd0);
        chk({tag, "_ctl"}, {27'd0, ex_wen, mem_wen, wb_wen, if_hold, bubble}, 32'd0);
    endtask

    initial begin
        #12;
        all_zero("reset_state");
`ifdef YSYX_040750_HAZARD_STAT_EN
        chk("stat_reset", lu_cnt | fwd_cnt, 32'd0);
`endif
        rst = 0;
        tick();

        // add x5,x1,x2 ; add x6,x5,x7
        id(1, 5, 1, 0, 1, 1, 2, 1); tick();
        id(1, 6, 1, 0, 5, 1, 7, 1); #1;
        chk("raw_ex_no_stall", {31'd0, if_hold}, 32'd0);
        tick();
        chk("raw_ex_vec", {30'd0, ex_stall}, 32'd2);
        chk("raw_ex_wen", {31'd0, ex_wen}, 32'd1);
        drain();

        // add x5 ; nop ; nop ; sub x8,x1,x5
        id(1, 5, 1, 0, 1, 1, 2, 1); tick();
        nop(); tick(); tick();
        id(1, 8, 1, 0, 1, 1, 5, 1); tick();
        chk("raw_wb_vec", {26'd0, ex_stall, mem_stall, wb_stall}, 32'b00_00_01);
        drain();

        // ld x10 ; add x11,x10,x10
        id(1, 10, 1, 1, 1, 1, 0, 0); tick();
        id(1, 11, 1, 0, 10, 1, 10, 1); #1;
        chk("lu_hold", {30'd0, if_hold, bubble}, 32'd3);
        tick();
        chk("lu_one_cycle", {30'd0, if_hold, bubble}, 32'd0);
        chk("lu_bubble_vec", {26'd0, ex_stall, mem_stall, wb_stall}, 32'd0);
        tick();
        chk("lu_mem_vec", {28'd0, ex_stall, mem_stall}, 32'b00_11);
        chk("lu_mem_wen", {31'd0, mem_wen}, 32'd1);
        drain();

        // x0 writers and readers, including a load to x0
        id(1, 0, 1, 0, 1, 1, 2, 1); tick();
        id(1, 0, 1, 1, 0, 1, 0, 1); #1;
        chk("x0_no_lu", {31'd0, if_hold}, 32'd0);
        tick();
        id(1, 3, 1, 0, 0, 1, 0, 1); #1;
        chk("x0_no_lu2", {31'd0, bubble}, 32'd0);
        tick();
        all_zero("x0");
        drain();

        // load-use pending under flush
        id(1, 10, 1, 1, 1, 1, 0, 0); tick();
        id(1, 11, 1, 0, 10, 1, 10, 1); flush = 1; #1;
        chk("flush_no_bubble", {30'd0, if_hold, bubble}, 32'd0);
        tick();
        flush = 0; nop(); #1;
        all_zero("flush_after");
        drain();

        // load-use frozen for 3 cycles, then proceeds
        id(1, 12, 1, 1, 1, 1, 0, 0); tick();
        id(1, 13, 1, 0, 12, 1, 0, 0); #1;
        chk("hold_lu", {30'd0, if_hold, bubble}, 32'd3);
        pipe_hold = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_stable", {24'd0, if_hold, bubble, ex_stall, mem_stall, wb_stall}, 32'b11_00_00_00);
        end
        pipe_hold = 0; tick();
        chk("hold_release", {30'd0, if_hold, bubble}, 32'd0);
        tick();
        chk("hold_mem_vec", {28'd0, ex_stall, mem_stall}, 32'b00_10);
        drain();

        // back-to-back writers of x5: all hits reported
        id(1, 5, 1, 0, 1, 1, 2, 1); tick();
        id(1, 5, 1, 0, 3, 1, 4, 1); tick();
        id(1, 9, 1, 0, 5, 1, 5, 1); tick();
        chk("multi_hit", {28'd0, ex_stall, mem_stall}, 32'b11_11);
        drain();

        // asynchronous reset with a dependent instruction in ID_EX
        id(1, 5, 1, 0, 1, 1, 2, 1); tick();
        id(1, 6, 1, 0, 5, 1, 0, 0); tick();
        chk("pre_reset_vec", {30'd0, ex_stall}, 32'd2);
        rst = 1; #1;
        all_zero("async_reset");
        #1 rst = 0;
`ifdef YSYX_040750_HAZARD_STAT_EN
        chk("stat_mid_reset", lu_cnt, 32'd0);
`endif
        id(1, 7, 1, 0, 5, 1, 6, 1); tick();
        all_zero("no_stale");

        // single load-use after reset
        id(1, 20, 1, 1, 1, 1, 0, 0); tick();
        id(1, 21, 1, 0, 20, 1, 0, 0); tick();
        tick();
        nop(); tick();
`ifdef YSYX_040750_HAZARD_STAT_EN
        chk("stat_lu_one", lu_cnt, 32'd1);
`endif
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_040750_hazard_unit.md
Name: ysyx_040750_hazard_unit

Overview:
- Producer side of operand forwarding for the 5-stage pipeline.
- Tracks destination registers of in-flight instructions (ID_EX, EX_MEM, MEM_WB slots) and compares them with the source registers of the instruction in ID.
- Registers per-stage match vectors that the forward unit consumes when that instruction sits in ID_EX; detects load-use hazards and drives stall/bubble control.

Parameters:
- REG_AW, 5, register index width
- NREG_ZERO, 0, hardwired-zero register index; never matched

Ports:
- I_sys_clk  input  1  clock
- I_rst  input  1  asynchronous reset, active-high
- I_ID_valid  input  1  ID holds a real instruction
- I_ID_rs1  input  REG_AW  ID source 1 index
- I_ID_rs2  input  REG_AW  ID source 2 index
- I_ID_rs1_use  input  1  ID reads rs1
- I_ID_rs2_use  input  1  ID reads rs2
- I_ID_rd  input  REG_AW  ID destination index
- I_ID_reg_wen  input  1  ID writes rd
- I_ID_is_load  input  1  ID is a load
- I_pipe_hold  input  1  global freeze (memory busy); all state holds
- I_flush  input  1  redirect; kill ID and ID_EX contents
- O_EX_stall  output  2  {rs1,rs2} match vs EX_MEM producer, aligned to ID_EX
- O_MEM_stall  output  2  {rs1,rs2} match vs MEM_WB producer
- O_WB_stall  output  2  {rs1,rs2} match vs WB producer
- O_EX_reg_wen  output  1  EX_MEM slot valid & writes
- O_MEM_reg_wen  output  1  MEM_WB slot valid & writes
- O_WB_reg_wen  output  1  WB slot valid & writes
- O_IF_ID_hold  output  1  freeze PC and IF_ID (load-use)
- O_ID_EX_bubble  output  1  load NOP into ID_EX

Behaviour:
- Reset (async, immediate): all slot valids 0, all O_*_stall 2'b00, O_*_reg_wen 0, O_IF_ID_hold 0, O_ID_EX_bubble 0.
- Tracker: 4 slots S0 (ID_EX), S1 (EX_MEM), S2 (MEM_WB), S3 (WB), each holding {valid, rd, wen, is_load}.
- Advance: on each clock edge with I_pipe_hold=0, S3<=S2, S2<=S1, S1<=S0, S0<=ID entry.
- ID entry is {I_ID_valid, I_ID_rd, I_ID_reg_wen, I_ID_is_load}. It is invalid when O_ID_EX_bubble=1 or I_flush=1.
- O_*_reg_wen = slot valid & wen & (rd != NREG_ZERO), for S1, S2, S3 respectively.
- Match, combinational at ID, per source: hit_k = use & (rs != NREG_ZERO) & (rs == rd_k) & wen_k & valid_k.
- Source k for each registered output:
  - O_EX_stall: compare against S0, since it becomes EX_MEM when ID enters EX.
  - O_MEM_stall: compare against S1.
  - O_WB_stall: compare against S2.
- Match vectors are registered on advance, so latency is 1 cycle: they are valid during the cycle the instruction is in ID_EX. Bubble or flush loads 2'b00 into all three.
- Multiple simultaneous hits are all reported. The forward unit applies EX > MEM > WB priority.
- Load-use:
  - Condition: S0.valid & S0.is_load & S0.wen & (hit on rs1 or rs2 against S0).
  - Response: O_IF_ID_hold=1 and O_ID_EX_bubble=1 combinationally, for exactly 1 advancing cycle.
  - On the next cycle the load is in S1. O_EX_stall must not be set for a load producer; instead O_MEM_stall is set when ID re-issues.
  - Rule: an S0 hit with S0.is_load=1 is never registered into O_EX_stall.
- I_pipe_hold=1: all registers hold; load-use outputs still reflect the current comparison.
- I_flush=1: S0 and the incoming ID entry are cleared on the edge, and hold/bubble are suppressed. Flush has priority over load-use. Hold has priority over flush; a held flush takes effect on the first non-held edge.
- Reset mid-operation clears all slots, so no stale forwarding occurs after reset release.

Optional Feature:
- Macro: YSYX_040750_HAZARD_STAT_EN.
- Defined: adds 32-bit saturating counters and output ports O_lu_stall_cnt (load-use bubbles inserted) and O_fwd_cnt (advancing cycles with any registered match nonzero). Both clear on I_rst; neither increments while held.
- Undefined: no counters and no ports; functional behaviour is identical.

Test Plan:
- add x5 then add x6,x5,x7 back-to-back -> next cycle O_EX_stall=2'b10, O_EX_reg_wen=1, no stall.
- add x5; nop; nop; sub x8,x1,x5 -> O_WB_stall=2'b01 when sub is in ID_EX; the others are 00.
- ld x10 then add x11,x10,x10 -> O_IF_ID_hold=O_ID_EX_bubble=1 for one cycle, then O_MEM_stall=2'b11, O_EX_stall=2'b00.
- Writes to x0 followed by readers of x0 -> all match vectors 00 and O_*_reg_wen=0.
- Load-use pending while I_flush=1 -> no bubble, S0 cleared, next-cycle vectors 00. Same with I_pipe_hold=1 for 3 cycles -> outputs stable, then proceed.
- Assert I_rst mid-stream with a dependent instruction in ID_EX -> outputs 0 immediately, without waiting for a clock edge. With STAT_EN, counters read 0 after reset and 1 after a single load-use.
